// File: rtl/axi_ram_arb2.sv
// axi_ram_arb2: shares one AXI4 RAM slave between two AXI4 masters, reads and writes arbitrated
// independently (round-robin, one transaction per direction in flight, payloads pass through).
module axi_ram_arb2 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH/8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // Every channel is AXI valid/ready: a beat moves on the rising edge where both are high,
    // and a source never waits for ready before raising valid.
    input  logic [ID_WIDTH-1:0]   s0_axi_awid,    s1_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s0_axi_awaddr,  s1_axi_awaddr,
    input  logic [7:0]            s0_axi_awlen,   s1_axi_awlen,
    input  logic [2:0]            s0_axi_awsize,  s1_axi_awsize,
    input  logic [1:0]            s0_axi_awburst, s1_axi_awburst,
    input  logic                  s0_axi_awlock,  s1_axi_awlock,
    input  logic [3:0]            s0_axi_awcache, s1_axi_awcache,
    input  logic [2:0]            s0_axi_awprot,  s1_axi_awprot,
    input  logic                  s0_axi_awvalid, s1_axi_awvalid,
    output logic                  s0_axi_awready, s1_axi_awready,
    input  logic [DATA_WIDTH-1:0] s0_axi_wdata,   s1_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s0_axi_wstrb,   s1_axi_wstrb,
    input  logic                  s0_axi_wlast,   s1_axi_wlast,
    input  logic                  s0_axi_wvalid,  s1_axi_wvalid,
    output logic                  s0_axi_wready,  s1_axi_wready,
    output logic [ID_WIDTH-1:0]   s0_axi_bid,     s1_axi_bid,
    output logic [1:0]            s0_axi_bresp,   s1_axi_bresp,
    output logic                  s0_axi_bvalid,  s1_axi_bvalid,
    input  logic                  s0_axi_bready,  s1_axi_bready,
    input  logic [ID_WIDTH-1:0]   s0_axi_arid,    s1_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,  s1_axi_araddr,
    input  logic [7:0]            s0_axi_arlen,   s1_axi_arlen,
    input  logic [2:0]            s0_axi_arsize,  s1_axi_arsize,
    input  logic [1:0]            s0_axi_arburst, s1_axi_arburst,
    input  logic                  s0_axi_arlock,  s1_axi_arlock,
    input  logic [3:0]            s0_axi_arcache, s1_axi_arcache,
    input  logic [2:0]            s0_axi_arprot,  s1_axi_arprot,
    input  logic                  s0_axi_arvalid, s1_axi_arvalid,
    output logic                  s0_axi_arready, s1_axi_arready,
    output logic [ID_WIDTH-1:0]   s0_axi_rid,     s1_axi_rid,
    output logic [DATA_WIDTH-1:0] s0_axi_rdata,   s1_axi_rdata,
    output logic [1:0]            s0_axi_rresp,   s1_axi_rresp,
    output logic                  s0_axi_rlast,   s1_axi_rlast,
    output logic                  s0_axi_rvalid,  s1_axi_rvalid,
    input  logic                  s0_axi_rready,  s1_axi_rready,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [1:0]            wr_state_o,
    output logic [1:0]            rd_state_o
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ADDR = 2'd1, ST_DATA = 2'd2, ST_RESP = 2'd3} state_t;

    state_t wr_state_q, wr_state_d, rd_state_q, rd_state_d;
    logic   wr_grant_q, wr_grant_d, wr_prio_q, wr_prio_d;
    logic   rd_grant_q, rd_grant_d, rd_prio_q, rd_prio_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= ST_IDLE;
            wr_grant_q <= 1'b0;
            wr_prio_q  <= 1'b0;
            rd_state_q <= ST_IDLE;
            rd_grant_q <= 1'b0;
            rd_prio_q  <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_grant_q <= wr_grant_d;
            wr_prio_q  <= wr_prio_d;
            rd_state_q <= rd_state_d;
            rd_grant_q <= rd_grant_d;
            rd_prio_q  <= rd_prio_d;
        end
    end

    // A tie goes to the prio port; prio flips to the other port when a transaction retires.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_grant_d = wr_grant_q;
        wr_prio_d  = wr_prio_q;
        case (wr_state_q)
            ST_IDLE: if (s0_axi_awvalid || s1_axi_awvalid) begin
                wr_grant_d = (s0_axi_awvalid && s1_axi_awvalid) ? wr_prio_q : s1_axi_awvalid;
                wr_state_d = ST_ADDR;
            end
            ST_ADDR: if (m_axi_awvalid && m_axi_awready) wr_state_d = ST_DATA;
            ST_DATA: if (m_axi_wvalid && m_axi_wready && m_axi_wlast) wr_state_d = ST_RESP;
            default: if (m_axi_bvalid && m_axi_bready) begin
                wr_state_d = ST_IDLE;
                wr_prio_d  = ~wr_grant_q;
            end
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_grant_d = rd_grant_q;
        rd_prio_d  = rd_prio_q;
        case (rd_state_q)
            ST_IDLE: if (s0_axi_arvalid || s1_axi_arvalid) begin
                rd_grant_d = (s0_axi_arvalid && s1_axi_arvalid) ? rd_prio_q : s1_axi_arvalid;
                rd_state_d = ST_ADDR;
            end
            ST_ADDR: if (m_axi_arvalid && m_axi_arready) rd_state_d = ST_DATA;
            ST_DATA: if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
                rd_state_d = ST_IDLE;
                rd_prio_d  = ~rd_grant_q;
            end
            default: rd_state_d = ST_IDLE;
        endcase
    end

    // Payloads always follow the grant; only valid/ready are gated by the phase.
    always_comb begin
        m_axi_awid     = wr_grant_q ? s1_axi_awid    : s0_axi_awid;
        m_axi_awaddr   = wr_grant_q ? s1_axi_awaddr  : s0_axi_awaddr;
        m_axi_awlen    = wr_grant_q ? s1_axi_awlen   : s0_axi_awlen;
        m_axi_awsize   = wr_grant_q ? s1_axi_awsize  : s0_axi_awsize;
        m_axi_awburst  = wr_grant_q ? s1_axi_awburst : s0_axi_awburst;
        m_axi_awlock   = wr_grant_q ? s1_axi_awlock  : s0_axi_awlock;
        m_axi_awcache  = wr_grant_q ? s1_axi_awcache : s0_axi_awcache;
        m_axi_awprot   = wr_grant_q ? s1_axi_awprot  : s0_axi_awprot;
        m_axi_awvalid  = (wr_state_q == ST_ADDR) && (wr_grant_q ? s1_axi_awvalid : s0_axi_awvalid);
        s0_axi_awready = (wr_state_q == ST_ADDR) && !wr_grant_q && m_axi_awready;
        s1_axi_awready = (wr_state_q == ST_ADDR) &&  wr_grant_q && m_axi_awready;
        m_axi_wdata    = wr_grant_q ? s1_axi_wdata : s0_axi_wdata;
        m_axi_wstrb    = wr_grant_q ? s1_axi_wstrb : s0_axi_wstrb;
        m_axi_wlast    = wr_grant_q ? s1_axi_wlast : s0_axi_wlast;
        m_axi_wvalid   = (wr_state_q == ST_DATA) && (wr_grant_q ? s1_axi_wvalid : s0_axi_wvalid);
        s0_axi_wready  = (wr_state_q == ST_DATA) && !wr_grant_q && m_axi_wready;
        s1_axi_wready  = (wr_state_q == ST_DATA) &&  wr_grant_q && m_axi_wready;
        m_axi_bready   = (wr_state_q == ST_RESP) && (wr_grant_q ? s1_axi_bready : s0_axi_bready);
        s0_axi_bvalid  = (wr_state_q == ST_RESP) && !wr_grant_q && m_axi_bvalid;
        s1_axi_bvalid  = (wr_state_q == ST_RESP) &&  wr_grant_q && m_axi_bvalid;
    end

    always_comb begin
        m_axi_arid     = rd_grant_q ? s1_axi_arid    : s0_axi_arid;
        m_axi_araddr   = rd_grant_q ? s1_axi_araddr  : s0_axi_araddr;
        m_axi_arlen    = rd_grant_q ? s1_axi_arlen   : s0_axi_arlen;
        m_axi_arsize   = rd_grant_q ? s1_axi_arsize  : s0_axi_arsize;
        m_axi_arburst  = rd_grant_q ? s1_axi_arburst : s0_axi_arburst;
        m_axi_arlock   = rd_grant_q ? s1_axi_arlock  : s0_axi_arlock;
        m_axi_arcache  = rd_grant_q ? s1_axi_arcache : s0_axi_arcache;
        m_axi_arprot   = rd_grant_q ? s1_axi_arprot  : s0_axi_arprot;
        m_axi_arvalid  = (rd_state_q == ST_ADDR) && (rd_grant_q ? s1_axi_arvalid : s0_axi_arvalid);
        s0_axi_arready = (rd_state_q == ST_ADDR) && !rd_grant_q && m_axi_arready;
        s1_axi_arready = (rd_state_q == ST_ADDR) &&  rd_grant_q && m_axi_arready;
        m_axi_rready   = (rd_state_q == ST_DATA) && (rd_grant_q ? s1_axi_rready : s0_axi_rready);
        s0_axi_rvalid  = (rd_state_q == ST_DATA) && !rd_grant_q && m_axi_rvalid;
        s1_axi_rvalid  = (rd_state_q == ST_DATA) &&  rd_grant_q && m_axi_rvalid;
    end

    assign s0_axi_bid   = m_axi_bid;
    assign s1_axi_bid   = m_axi_bid;
    assign s0_axi_bresp = m_axi_bresp;
    assign s1_axi_bresp = m_axi_bresp;
    assign s0_axi_rid   = m_axi_rid;
    assign s1_axi_rid   = m_axi_rid;
    assign s0_axi_rdata = m_axi_rdata;
    assign s1_axi_rdata = m_axi_rdata;
    assign s0_axi_rresp = m_axi_rresp;
    assign s1_axi_rresp = m_axi_rresp;
    assign s0_axi_rlast = m_axi_rlast;
    assign s1_axi_rlast = m_axi_rlast;

    assign wr_state_o = wr_state_q;
    assign rd_state_o = rd_state_q;

endmodule

// File: tb/tb_axi_ram_arb2.sv
// Bench for axi_ram_arb2: two driven masters, a behavioural RAM slave, and a scoreboard
// that checks every B and R beat delivered to each master against its expected queue.
module tb_axi_ram_arb2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // master-side signals, index = master number
  logic [1:0]  s_awvalid, s_awready, s_awlock, s_wvalid, s_wlast, s_wready;
  logic [1:0]  s_bvalid, s_bready, s_arvalid, s_arready, s_arlock, s_rvalid, s_rready, s_rlast;
  logic [7:0]  s_awid[2], s_awlen[2], s_arid[2], s_arlen[2], s_bid[2], s_rid[2];
  logic [15:0] s_awaddr[2], s_araddr[2];
  logic [2:0]  s_awsize[2], s_arsize[2], s_awprot[2], s_arprot[2];
  logic [1:0]  s_awburst[2], s_arburst[2], s_bresp[2], s_rresp[2];
  logic [3:0]  s_awcache[2], s_arcache[2], s_wstrb[2];
  logic [31:0] s_wdata[2], s_rdata[2];

  // RAM-side signals
  logic [7:0]  m_awid, m_awlen, m_arid, m_arlen, m_bid, m_rid;
  logic [15:0] m_awaddr, m_araddr;
  logic [2:0]  m_awsize, m_arsize, m_awprot, m_arprot;
  logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;
  logic [3:0]  m_awcache, m_arcache, m_wstrb;
  logic [31:0] m_wdata, m_rdata;
  logic        m_awlock, m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arlock, m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic [1:0]  wr_state, rd_state;

  axi_ram_arb2 dut (
    .clk(clk), .rst(rst),
    .s0_axi_awid(s_awid[0]), .s1_axi_awid(s_awid[1]),
    .s0_axi_awaddr(s_awaddr[0]), .s1_axi_awaddr(s_awaddr[1]),
    .s0_axi_awlen(s_awlen[0]), .s1_axi_awlen(s_awlen[1]),
    .s0_axi_awsize(s_awsize[0]), .s1_axi_awsize(s_awsize[1]),
    .s0_axi_awburst(s_awburst[0]), .s1_axi_awburst(s_awburst[1]),
    .s0_axi_awlock(s_awlock[0]), .s1_axi_awlock(s_awlock[1]),
    .s0_axi_awcache(s_awcache[0]), .s1_axi_awcache(s_awcache[1]),
    .s0_axi_awprot(s_awprot[0]), .s1_axi_awprot(s_awprot[1]),
    .s0_axi_awvalid(s_awvalid[0]), .s1_axi_awvalid(s_awvalid[1]),
    .s0_axi_awready(s_awready[0]), .s1_axi_awready(s_awready[1]),
    .s0_axi_wdata(s_wdata[0]), .s1_axi_wdata(s_wdata[1]),
    .s0_axi_wstrb(s_wstrb[0]), .s1_axi_wstrb(s_wstrb[1]),
    .s0_axi_wlast(s_wlast[0]), .s1_axi_wlast(s_wlast[1]),
    .s0_axi_wvalid(s_wvalid[0]), .s1_axi_wvalid(s_wvalid[1]),
    .s0_axi_wready(s_wready[0]), .s1_axi_wready(s_wready[1]),
    .s0_axi_bid(s_bid[0]), .s1_axi_bid(s_bid[1]),
    .s0_axi_bresp(s_bresp[0]), .s1_axi_bresp(s_bresp[1]),
    .s0_axi_bvalid(s_bvalid[0]), .s1_axi_bvalid(s_bvalid[1]),
    .s0_axi_bready(s_bready[0]), .s1_axi_bready(s_bready[1]),
    .s0_axi_arid(s_arid[0]), .s1_axi_arid(s_arid[1]),
    .s0_axi_araddr(s_araddr[0]), .s1_axi_araddr(s_araddr[1]),
    .s0_axi_arlen(s_arlen[0]), .s1_axi_arlen(s_arlen[1]),
    .s0_axi_arsize(s_arsize[0]), .s1_axi_arsize(s_arsize[1]),
    .s0_axi_arburst(s_arburst[0]), .s1_axi_arburst(s_arburst[1]),
    .s0_axi_arlock(s_arlock[0]), .s1_axi_arlock(s_arlock[1]),
    .s0_axi_arcache(s_arcache[0]), .s1_axi_arcache(s_arcache[1]),
    .s0_axi_arprot(s_arprot[0]), .s1_axi_arprot(s_arprot[1]),
    .s0_axi_arvalid(s_arvalid[0]), .s1_axi_arvalid(s_arvalid[1]),
    .s0_axi_arready(s_arready[0]), .s1_axi_arready(s_arready[1]),
    .s0_axi_rid(s_rid[0]), .s1_axi_rid(s_rid[1]),
    .s0_axi_rdata(s_rdata[0]), .s1_axi_rdata(s_rdata[1]),
    .s0_axi_rresp(s_rresp[0]), .s1_axi_rresp(s_rresp[1]),
    .s0_axi_rlast(s_rlast[0]), .s1_axi_rlast(s_rlast[1]),
    .s0_axi_rvalid(s_rvalid[0]), .s1_axi_rvalid(s_rvalid[1]),
    .s0_axi_rready(s_rready[0]), .s1_axi_rready(s_rready[1]),
    .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen),
    .m_axi_awsize(m_awsize), .m_axi_awburst(m_awburst), .m_axi_awlock(m_awlock),
    .m_axi_awcache(m_awcache), .m_axi_awprot(m_awprot),
    .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
    .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
    .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen),
    .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst), .m_axi_arlock(m_arlock),
    .m_axi_arcache(m_arcache), .m_axi_arprot(m_arprot),
    .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
    .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
    .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
    .wr_state_o(wr_state), .rd_state_o(rd_state)
  );

  // ---------------- behavioural RAM slave (256 words, address bit 11 answers SLVERR) ----------------
  logic [31:0] mem [256];
  logic        r_busy;
  logic [7:0]  r_idx, r_cnt, r_id, w_idx, w_id;
  logic [1:0]  r_resp, w_resp, w_ph;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5A5_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  initial for (int i = 0; i < 256; i++) mem[i] = init_word(i);

  assign m_arready = !r_busy;
  assign m_rvalid  = r_busy;
  assign m_rdata   = mem[r_idx];
  assign m_rlast   = (r_cnt == 8'd0);
  assign m_rid     = r_id;
  assign m_rresp   = r_resp;

  always @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
    end else if (!r_busy) begin
      if (m_arvalid) begin
        r_busy <= 1'b1;
        r_idx  <= m_araddr[9:2];
        r_cnt  <= m_arlen;
        r_id   <= m_arid;
        r_resp <= m_araddr[11] ? 2'b10 : 2'b00;
      end
    end else if (m_rready) begin
      r_idx <= r_idx + 8'd1;
      r_cnt <= r_cnt - 8'd1;
      if (r_cnt == 8'd0) r_busy <= 1'b0;
    end
  end

  assign m_awready = (w_ph == 2'd0);
  assign m_wready  = (w_ph == 2'd1);
  assign m_bvalid  = (w_ph == 2'd2);
  assign m_bid     = w_id;
  assign m_bresp   = w_resp;

  always @(posedge clk) begin
    if (rst) begin
      w_ph <= 2'd0;
    end else begin
      case (w_ph)
        2'd0: if (m_awvalid) begin
          w_ph   <= 2'd1;
          w_idx  <= m_awaddr[9:2];
          w_id   <= m_awid;
          w_resp <= m_awaddr[11] ? 2'b10 : 2'b00;
        end
        2'd1: if (m_wvalid) begin
          for (int k = 0; k < 4; k++)
            if (m_wstrb[k]) mem[w_idx][8*k +: 8] <= m_wdata[8*k +: 8];
          w_idx <= w_idx + 8'd1;
          if (m_wlast) w_ph <= 2'd2;
        end
        default: if (m_bready) w_ph <= 2'd0;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [256];
  logic [42:0] exp_r0_q[$], exp_r1_q[$];   // {id, data, resp, last}
  logic [9:0]  exp_b0_q[$], exp_b1_q[$];   // {id, resp}
  logic [0:0]  got_ord_q[$];               // master index of each completed read

  initial for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [42:0] got_r, exp_r;
    logic [9:0]  got_b, exp_b;
    logic        have;
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        if (s_rvalid[m] && s_rready[m]) begin
          got_r = {s_rid[m], s_rdata[m], s_rresp[m], s_rlast[m]};
          have  = (m == 0) ? (exp_r0_q.size() > 0) : (exp_r1_q.size() > 0);
          exp_r = '0;
          if (have) exp_r = (m == 0) ? exp_r0_q.pop_front() : exp_r1_q.pop_front();
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL r%0d_unexpected: got beat %0h, expected no beat", m, got_r);
          end else if (got_r !== exp_r) begin
            errors++;
            $display("FAIL r%0d_beat: got %0h expected %0h", m, got_r, exp_r);
          end
          if (s_rlast[m]) got_ord_q.push_back(1'(m));
        end
        if (s_bvalid[m] && s_bready[m]) begin
          got_b = {s_bid[m], s_bresp[m]};
          have  = (m == 0) ? (exp_b0_q.size() > 0) : (exp_b1_q.size() > 0);
          exp_b = '0;
          if (have) exp_b = (m == 0) ? exp_b0_q.pop_front() : exp_b1_q.pop_front();
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL b%0d_unexpected: got resp %0h, expected no resp", m, got_b);
          end else if (got_b !== exp_b) begin
            errors++;
            $display("FAIL b%0d_resp: got %0h expected %0h", m, got_b, exp_b);
          end
        end
      end
    end
  end

  // ---------------- driver tasks (start and end just after a rising edge) ----------------
  function automatic logic sig(input int k, input int m);
    case (k)
      0: return s_awready[m];
      1: return s_wready[m];
      2: return s_bvalid[m];
      default: return s_arready[m];
    endcase
  endfunction

  task automatic wait_sig(input int k, input int m, input string name);
    int n = 0;
    @(negedge clk);
    while (!sig(k, m) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!sig(k, m)) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: signal 0 after %0d cycles, required 1", name, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int m, input logic [15:0] addr, input logic [7:0] len,
                         input logic [7:0] id, input int hold_at, input int hold_n);
    int beats = 0;
    int budget = 0;
    logic done = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      logic [7:0]  idx;
      logic [42:0] e;
      idx = addr[9:2] + 8'(b);
      e = {id, ref_mem[idx], (addr[11] ? 2'b10 : 2'b00), (b == int'(len))};
      if (m == 0) exp_r0_q.push_back(e); else exp_r1_q.push_back(e);
    end
    s_arid[m] = id; s_araddr[m] = addr; s_arlen[m] = len; s_arvalid[m] = 1'b1;
    wait_sig(3, m, "ar");
    s_arvalid[m] = 1'b0;
    s_rready[m] = 1'b1;
    while (!done && budget < 200) begin
      @(negedge clk);
      budget++;
      if (s_rvalid[m]) begin
        beats++;
        done = s_rlast[m];
        @(posedge clk);
        #1;
        if (!done && beats == hold_at) begin
          s_rready[m] = 1'b0;
          repeat (hold_n) begin
            @(negedge clk);
            chk("bp_m_rready", 64'(m_rready), 64'd0);
            chk("bp_rvalid_held", 64'(s_rvalid[m]), 64'd1);
          end
          @(posedge clk);
          #1;
          s_rready[m] = 1'b1;
        end
      end
    end
    s_rready[m] = 1'b0;
    chk("rd_done", 64'(done), 64'd1);
    chk("rd_beats", 64'(beats), 64'(len) + 64'd1);
  endtask

  task automatic do_write(input int m, input logic [15:0] addr, input logic [7:0] len,
                          input logic [7:0] id, input logic [31:0] data0);
    for (int b = 0; b <= int'(len); b++) begin
      logic [7:0] idx;
      idx = addr[9:2] + 8'(b);
      ref_mem[idx] = data0 + 32'(b);
    end
    if (m == 0) exp_b0_q.push_back({id, (addr[11] ? 2'b10 : 2'b00)});
    else        exp_b1_q.push_back({id, (addr[11] ? 2'b10 : 2'b00)});
    s_awid[m] = id; s_awaddr[m] = addr; s_awlen[m] = len; s_awvalid[m] = 1'b1;
    wait_sig(0, m, "aw");
    s_awvalid[m] = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      s_wdata[m] = data0 + 32'(b);
      s_wstrb[m] = 4'hF;
      s_wlast[m] = (b == int'(len));
      s_wvalid[m] = 1'b1;
      wait_sig(1, m, "w");
    end
    s_wvalid[m] = 1'b0;
    s_wlast[m] = 1'b0;
    s_bready[m] = 1'b1;
    wait_sig(2, m, "b");
    s_bready[m] = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_s_rdy_vld"}, 64'({s_awready, s_wready, s_bvalid, s_arready, s_rvalid}), 64'd0);
    chk({name, "_m_rdy_vld"}, 64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 64'd0);
    chk({name, "_states"}, 64'({wr_state, rd_state}), 64'd0);
  endtask

  task automatic chk_order(input string name, input logic [1:0] exp);
    chk({name, "_count"}, 64'(got_ord_q.size()), 64'd2);
    if (got_ord_q.size() == 2) chk({name, "_order"}, 64'({got_ord_q[0], got_ord_q[1]}), 64'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    s_awvalid = '0; s_awlock = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0;
    s_arvalid = '0; s_arlock = '0; s_rready = '0;
    for (int m = 0; m < 2; m++) begin
      s_awid[m] = '0; s_awaddr[m] = '0; s_awlen[m] = '0; s_awsize[m] = 3'd2; s_awburst[m] = 2'b01;
      s_awcache[m] = '0; s_awprot[m] = '0; s_wdata[m] = '0; s_wstrb[m] = '0;
      s_arid[m] = '0; s_araddr[m] = '0; s_arlen[m] = '0; s_arsize[m] = 3'd2; s_arburst[m] = 2'b01;
      s_arcache[m] = '0; s_arprot[m] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // collision straight after reset: port 0 wins, then port 1
    got_ord_q.delete();
    fork
      do_read(0, 16'h0030, 8'd1, 8'h01, -1, 0);
      do_read(1, 16'h0050, 8'd1, 8'h02, -1, 0);
    join
    chk_order("coll1", 2'b01);

    // single 4-beat read with arbitration latency check
    fork
      do_read(0, 16'h0010, 8'd3, 8'h11, -1, 0);
      begin
        @(negedge clk);
        chk("lat_idle_arvalid", 64'(m_arvalid), 64'd0);
        @(negedge clk);
        chk("lat_addr_ar", 64'({m_arvalid, m_araddr, m_arid, m_arlen}), {39'd0, 1'b1, 16'h0010, 8'h11, 8'd3});
      end
    join

    // port 0 was served last, so port 1 now wins the tie
    got_ord_q.delete();
    fork
      do_read(0, 16'h0060, 8'd1, 8'h03, -1, 0);
      do_read(1, 16'h0070, 8'd1, 8'h04, -1, 0);
    join
    chk_order("coll2", 2'b10);

    // write then readback
    do_write(1, 16'h0020, 8'd0, 8'h21, 32'hDEAD_BEEF);
    do_read(0, 16'h0020, 8'd0, 8'h05, -1, 0);

    // overlapping write and read on different ports
    fork
      do_write(0, 16'h0040, 8'd3, 8'h31, 32'h1000_0000);
      do_read(1, 16'h0080, 8'd3, 8'h41, -1, 0);
    join
    do_read(1, 16'h0040, 8'd3, 8'h42, -1, 0);

    // master backpressure: rready low for 5 cycles after beat 2
    do_read(0, 16'h0100, 8'd3, 8'h51, 2, 5);

    // error responses pass through unchanged
    do_write(1, 16'h0800, 8'd0, 8'h61, 32'hCAFE_0001);
    do_read(0, 16'h0800, 8'd1, 8'h62, -1, 0);

    // reset in the middle of a write burst
    s_awid[0] = 8'h71; s_awaddr[0] = 16'h0200; s_awlen[0] = 8'd3; s_awvalid[0] = 1'b1;
    wait_sig(0, 0, "rst_aw");
    s_awvalid[0] = 1'b0;
    s_wdata[0] = 32'h7777_0000; s_wstrb[0] = 4'hF; s_wlast[0] = 1'b0; s_wvalid[0] = 1'b1;
    wait_sig(1, 0, "rst_w");
    ref_mem[8'h80] = 32'h7777_0000;
    chk("pre_rst_wr_state", 64'(wr_state), 64'd2);
    rst = 1'b1;
    s_wvalid[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_idle("rst_mid");
    @(posedge clk);
    #1 rst = 1'b0;
    do_write(0, 16'h0300, 8'd1, 8'h72, 32'h3300_0000);
    do_read(0, 16'h0300, 8'd1, 8'h73, -1, 0);

    repeat (5) @(posedge clk);
    chk("leftover_expected", 64'(exp_r0_q.size() + exp_r1_q.size() + exp_b0_q.size() + exp_b1_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
